blackjack_round_sequencer: RTL

//  Sequences one blackjack round over two handController instances (player, dealer) and a card source.

---
 rtl/blackjack_round_sequencer.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/blackjack_round_sequencer.sv
// Round sequencer for one blackjack hand: clears both hands, deals P/D/P/D, serves the
// player's hit/stand, runs dealer draws and resolves the round (5-card Charlie, tallies).
module blackjack_round_sequencer #(
    parameter int CARD_W       = 4,
    parameter int SUM_W        = 5,
    parameter int DEALER_STAND = 17,
    parameter int MAX_CARDS    = 5,
    parameter int STAT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_deal,
    input  logic              i_hit,
    input  logic              i_stand,
    output logic              o_card_req,
    input  logic              i_card_valid,
    input  logic [CARD_W-1:0] i_card,
    output logic [CARD_W-1:0] o_new_card,
    output logic              o_player_add,
    output logic              o_dealer_add,
    output logic              o_hand_clear,
    input  logic [SUM_W-1:0]  i_player_sum,
    input  logic [2:0]        i_player_count,
    input  logic [SUM_W-1:0]  i_dealer_sum,
    input  logic [2:0]        i_dealer_count,
    output logic              o_player_turn,
    output logic              o_result_valid,
    output logic [1:0]        o_result,
    output logic [STAT_W-1:0] o_wins,
    output logic [STAT_W-1:0] o_losses
);

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_CLEAR       = 3'd1;
    localparam logic [2:0] ST_FETCH       = 3'd2;
    localparam logic [2:0] ST_ADD         = 3'd3;
    localparam logic [2:0] ST_CHECK       = 3'd4;
    localparam logic [2:0] ST_PLAYER_TURN = 3'd5;
    localparam logic [2:0] ST_DEALER_TURN = 3'd6;
    localparam logic [2:0] ST_DONE        = 3'd7;

    localparam logic [1:0] RES_NONE = 2'd0;
    localparam logic [1:0] RES_WIN  = 2'd1;
    localparam logic [1:0] RES_LOSE = 2'd2;
    localparam logic [1:0] RES_PUSH = 2'd3;

    localparam logic [SUM_W-1:0] BUST_LIMIT = SUM_W'(32'd21);
    localparam logic [SUM_W-1:0] STAND_SUM  = SUM_W'(DEALER_STAND);
    localparam logic [2:0]       HAND_MAX   = 3'(MAX_CARDS);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        logic [STAT_W-1:0] res;
        if (&value) begin
            res = value;
        end else begin
            res = value + STAT_W'(1'b1);
        end
        return res;
    endfunction

    // Showdown once the dealer has finished drawing; the player is known not to be bust here.
    function automatic logic [1:0] settle(input logic [SUM_W-1:0] player_sum,
                                          input logic [SUM_W-1:0] dealer_sum);
        logic [1:0] res;
        if (dealer_sum > BUST_LIMIT) begin
            res = RES_WIN;
        end else if (player_sum > dealer_sum) begin
            res = RES_WIN;
        end else if (player_sum == dealer_sum) begin
            res = RES_PUSH;
        end else begin
            res = RES_LOSE;
        end
        return res;
    endfunction

    logic [2:0]        state_r;
    logic [1:0]        dcnt_r;
    logic              tgt_r;
    logic              dealing_r;
    logic              dealer_eval_r;

    logic [2:0]        state_s;
    logic [1:0]        dcnt_s;
    logic              tgt_s;
    logic              dealing_s;
    logic              dealer_eval_s;
    logic              card_req_s;
    logic [CARD_W-1:0] new_card_s;
    logic              player_add_s;
    logic              dealer_add_s;
    logic              hand_clear_s;
    logic              player_turn_s;
    logic              result_valid_s;
    logic [1:0]        result_s;
    logic [STAT_W-1:0] wins_s;
    logic [STAT_W-1:0] losses_s;
    logic              resolve_s;
    logic [1:0]        outcome_s;

    // Next-state and next-output decode; every output is the registered copy of its _s value.
    always_comb begin
        state_s        = state_r;
        dcnt_s         = dcnt_r;
        tgt_s          = tgt_r;
        dealing_s      = dealing_r;
        dealer_eval_s  = dealer_eval_r;
        card_req_s     = 1'b0;
        new_card_s     = o_new_card;
        player_add_s   = 1'b0;
        dealer_add_s   = 1'b0;
        hand_clear_s   = 1'b0;
        player_turn_s  = 1'b0;
        result_valid_s = o_result_valid;
        result_s       = o_result;
        wins_s         = o_wins;
        losses_s       = o_losses;
        resolve_s      = 1'b0;
        outcome_s      = RES_NONE;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (i_deal) begin
                    state_s        = ST_CLEAR;
                    hand_clear_s   = 1'b1;
                    result_s       = RES_NONE;
                    result_valid_s = 1'b0;
                    dcnt_s         = 2'd0;
                    dealing_s      = 1'b1;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CLEAR: begin
                state_s    = ST_FETCH;
                tgt_s      = dcnt_r[0];
                card_req_s = 1'b1;
            end
            ST_FETCH: begin
                if (i_card_valid) begin
                    state_s      = ST_ADD;
                    new_card_s   = i_card;
                    player_add_s = ~tgt_r;
                    dealer_add_s = tgt_r;
                end else begin
                    card_req_s = 1'b1;
                end
            end
            ST_ADD: begin
                state_s = ST_CHECK;
            end
            // Hand sums reflect the card added in ADD by the time this state is evaluated.
            ST_CHECK: begin
                if (dealing_r) begin
                    if (dcnt_r < 2'd3) begin
                        dcnt_s     = dcnt_r + 2'd1;
                        tgt_s      = ~dcnt_r[0];
                        state_s    = ST_FETCH;
                        card_req_s = 1'b1;
                    end else begin
                        dealing_s     = 1'b0;
                        state_s       = ST_PLAYER_TURN;
                        player_turn_s = 1'b1;
                    end
                end else if (!tgt_r) begin
                    if (i_player_sum > BUST_LIMIT) begin
                        resolve_s = 1'b1;
                        outcome_s = RES_LOSE;
                    end else if (i_player_count == HAND_MAX) begin
                        resolve_s = 1'b1;
                        outcome_s = RES_WIN;
                    end else begin
                        state_s       = ST_PLAYER_TURN;
                        player_turn_s = 1'b1;
                    end
                end else begin
                    state_s       = ST_DEALER_TURN;
                    dealer_eval_s = 1'b0;
                end
            end
            ST_PLAYER_TURN: begin
                if (i_hit) begin
                    state_s    = ST_FETCH;
                    tgt_s      = 1'b0;
                    card_req_s = 1'b1;
                end else if (i_stand) begin
                    state_s       = ST_DEALER_TURN;
                    dealer_eval_s = 1'b0;
                end else begin
                    player_turn_s = 1'b1;
                end
            end
            // First cycle in this state only arms the evaluation; the decision is taken on the next.
            ST_DEALER_TURN: begin
                if (!dealer_eval_r) begin
                    dealer_eval_s = 1'b1;
                end else if ((i_dealer_sum < STAND_SUM) && (i_dealer_count < HAND_MAX)) begin
                    state_s    = ST_FETCH;
                    tgt_s      = 1'b1;
                    card_req_s = 1'b1;
                end else begin
                    resolve_s = 1'b1;
                    outcome_s = settle(i_player_sum, i_dealer_sum);
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (resolve_s) begin
            state_s        = ST_DONE;
            result_s       = outcome_s;
            result_valid_s = 1'b1;
            if (outcome_s == RES_WIN) begin
                wins_s = sat_inc(o_wins);
            end else if (outcome_s == RES_LOSE) begin
                losses_s = sat_inc(o_losses);
            end else begin
                wins_s = o_wins;
            end
        end else begin
            result_valid_s = result_valid_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_r        <= ST_IDLE;
            dcnt_r         <= 2'd0;
            tgt_r          <= 1'b0;
            dealing_r      <= 1'b0;
            dealer_eval_r  <= 1'b0;
            o_card_req     <= 1'b0;
            o_new_card     <= '0;
            o_player_add   <= 1'b0;
            o_dealer_add   <= 1'b0;
            o_hand_clear   <= 1'b0;
            o_player_turn  <= 1'b0;
            o_result_valid <= 1'b0;
            o_result       <= RES_NONE;
            o_wins         <= '0;
            o_losses       <= '0;
        end else begin
            state_r        <= state_s;
            dcnt_r         <= dcnt_s;
            tgt_r          <= tgt_s;
            dealing_r      <= dealing_s;
            dealer_eval_r  <= dealer_eval_s;
            o_card_req     <= card_req_s;
            o_new_card     <= new_card_s;
            o_player_add   <= player_add_s;
            o_dealer_add   <= dealer_add_s;
            o_hand_clear   <= hand_clear_s;
            o_player_turn  <= player_turn_s;
            o_result_valid <= result_valid_s;
            o_result       <= result_s;
            o_wins         <= wins_s;
            o_losses       <= losses_s;
        end
    end

endmodule
